// File: rtl/tensor_core_loader.sv
// Byte-stream loader for small_tensor_core: assembles two signed 3x3 operands,
// issues a one-cycle start with the op select, then stalls the stream while the core computes.
module tensor_core_loader #(
  parameter int BUS_WIDTH          = 7,
  parameter int MATRIX_BUSY_CYCLES = 9,
  parameter int RELU_BUSY_CYCLES   = 1
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic [BUS_WIDTH:0]          data_in,
  input  logic                        data_valid_in,
  output logic                        data_ready_out,
  output logic signed [BUS_WIDTH:0]   tensor_core_input1 [3][3],
  output logic signed [BUS_WIDTH:0]   tensor_core_input2 [3][3],
  output logic [1:0]                  matrix_operation_select,
  output logic                        should_start_tensor_core,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        error_out,
  output logic [2:0]                  debug_state_out
);

  // Handshake: a beat is any cycle with data_valid_in && data_ready_out; only beats change load state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam int CNT_MAX = (MATRIX_BUSY_CYCLES > RELU_BUSY_CYCLES) ? MATRIX_BUSY_CYCLES
                                                                   : RELU_BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             ready_q, start_q, busy_q, done_q, error_q;
  logic [1:0]       row, col;
  logic             beat;

  assign beat = data_valid_in && ready_q;

  // Row-major element index to (row, col).
  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (idx_q)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tensor_core_input1[r][c] <= '0;
          tensor_core_input2[r][c] <= '0;
        end
      end
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (beat) begin
            case (data_in[1:0])
              2'b00, 2'b01: begin
                op_q    <= data_in[1:0];
                idx_q   <= '0;
                state_q <= LOAD1;
                busy_q  <= 1'b1;
              end
              2'b10: begin
                op_q    <= data_in[1:0];
                state_q <= START;
                start_q <= 1'b1;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
              default: error_q <= 1'b1;
            endcase
          end
        end
        LOAD1: begin
          if (beat) begin
            tensor_core_input1[row][col] <= data_in;
            if (idx_q == 4'd8) begin
              idx_q   <= '0;
              state_q <= LOAD2;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        LOAD2: begin
          if (beat) begin
            tensor_core_input2[row][col] <= data_in;
            if (idx_q == 4'd8) begin
              idx_q   <= '0;
              state_q <= START;
              start_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        START: begin
          cnt_q   <= (op_q == 2'b10) ? CNT_W'(RELU_BUSY_CYCLES) : CNT_W'(MATRIX_BUSY_CYCLES);
          state_q <= WAIT;
        end
        WAIT: begin
          // Leave on the cycle the counter shows 1, so WAIT lasts exactly the busy count.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready_out           = ready_q;
  assign matrix_operation_select  = op_q;
  assign should_start_tensor_core = start_q;
  assign busy_out                 = busy_q;
  assign done_out                 = done_q;
  assign error_out                = error_q;
  assign debug_state_out          = state_q;

endmodule

// File: tb/tb_tensor_core_loader.sv
// Directed bench for tensor_core_loader: scenario tasks with hand-computed expectations.
module tb_tensor_core_loader;

  logic              clk;
  logic              rst;
  logic [7:0]        data;
  logic              valid;
  logic              ready;
  logic signed [7:0] in1 [3][3];
  logic signed [7:0] in2 [3][3];
  logic [1:0]        op_sel;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  tensor_core_loader dut (
    .clock_in                 (clk),
    .reset_in                 (rst),
    .data_in                  (data),
    .data_valid_in            (valid),
    .data_ready_out           (ready),
    .tensor_core_input1       (in1),
    .tensor_core_input2       (in2),
    .matrix_operation_select  (op_sel),
    .should_start_tensor_core (start),
    .busy_out                 (busy),
    .done_out                 (done),
    .error_out                (err),
    .debug_state_out          (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (start) start_cnt++;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte until accepted; returns in the cycle after the beat.
  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    data  = d;
    valid = 1'b1;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!ready) begin
      n_err++;
      $display("FAIL send_beat_timeout: ready=%0b required 1", ready);
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", ready); end
    n_cmp++; if ({busy, start, done, err} !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", {busy, start, done, err}); end
    n_cmp++; if (op_sel !== 2'b00) begin n_err++; $display("FAIL reset_op: got %b want 00", op_sel); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (in1[r][c] !== 8'sd0 || in2[r][c] !== 8'sd0) begin n_err++;
          $display("FAIL reset_operand[%0d][%0d]: got %0d/%0d want 0/0", r, c, in1[r][c], in2[r][c]); end
      end
  endtask

  task automatic test_multiply();
    logic [7:0] b_id [9];
    int bad;
    int cyc;
    b_id = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    send_beat(8'h00);
    for (int i = 0; i < 9; i++) send_beat(8'(i + 1));
    for (int i = 0; i < 9; i++) send_beat(b_id[i]);
    // Now in L+1
    n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL mul_start: got %0b want 1", start); end
    n_cmp++; if (op_sel !== 2'b00) begin n_err++; $display("FAIL mul_op: got %b want 00", op_sel); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mul_ready_L1: got %0b want 0", ready); end
    bad = 0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (ready !== 1'b0 || start !== 1'b0 || done !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mul_wait_window: bad_cycles=%0d want 0", bad); end
    tick();
    n_cmp++; if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL mul_done_L11: done=%0b ready=%0b busy=%0b want 1 1 0", done, ready, busy); end
    n_cmp++; if (in1[2][1] !== 8'sd8) begin n_err++; $display("FAIL mul_a21: got %0d want 8", in1[2][1]); end
    n_cmp++; if (in2[1][1] !== 8'sd1) begin n_err++; $display("FAIL mul_b11: got %0d want 1", in2[1][1]); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (in1[i/3][i%3] !== 8'(i + 1) || in2[i/3][i%3] !== b_id[i]) begin n_err++;
        $display("FAIL mul_elem%0d: got %0d/%0d want %0d/%0d", i, in1[i/3][i%3], in2[i/3][i%3], i + 1, b_id[i]); end
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mul_done_once: got %0b want 0", done); end
    cyc = 0;
  endtask

  task automatic test_relu();
    int s0;
    s0 = start_cnt;
    send_beat(8'h02);
    n_cmp++; if (start !== 1'b1 || op_sel !== 2'b10) begin n_err++;
      $display("FAIL relu_start_H1: start=%0b op=%b want 1 10", start, op_sel); end
    tick();
    n_cmp++; if (start !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL relu_H2: start=%0b done=%0b busy=%0b want 0 0 1", start, done, busy); end
    tick();
    n_cmp++; if (done !== 1'b1 || ready !== 1'b1) begin n_err++;
      $display("FAIL relu_done_H3: done=%0b ready=%0b want 1 1", done, ready); end
    n_cmp++; if (in1[0][0] !== 8'sd1 || in1[2][2] !== 8'sd9 || in2[0][0] !== 8'sd1 || in2[0][1] !== 8'sd0) begin
      n_err++; $display("FAIL relu_operands_held: a00=%0d a22=%0d b00=%0d b01=%0d want 1 9 1 0",
                        in1[0][0], in1[2][2], in2[0][0], in2[0][1]); end
    tick();
    n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL relu_start_count: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_illegal();
    logic [7:0] hdrs [2];
    int s0;
    hdrs = '{8'h03, 8'hFF};
    s0 = start_cnt;
    for (int h = 0; h < 2; h++) begin
      send_beat(hdrs[h]);
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err_%0d: got %0b want 1", h, err); end
      n_cmp++; if (dbg_state !== 3'd0 || busy !== 1'b0) begin n_err++;
        $display("FAIL illegal_idle_%0d: state=%0d busy=%0b want 0 0", h, dbg_state, busy); end
      n_cmp++; if (op_sel !== 2'b10) begin n_err++; $display("FAIL illegal_op_%0d: got %b want 10", h, op_sel); end
      tick();
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL illegal_err_pulse_%0d: got %0b want 0", h, err); end
    end
    n_cmp++; if (start_cnt !== s0) begin n_err++; $display("FAIL illegal_no_start: got %0d want %0d", start_cnt, s0); end
  endtask

  task automatic test_add_gaps();
    int s0;
    int cyc;
    s0 = start_cnt;
    send_beat(8'h01);
    for (int i = 0; i < 18; i++) begin
      send_beat(8'd100);
      if (i != 17) tick();
    end
    n_cmp++; if (start !== 1'b1 || start_cnt !== s0) begin n_err++;
      $display("FAIL add_start_after_18: start=%0b early_starts=%0d want 1 0", start, start_cnt - s0); end
    n_cmp++; if (op_sel !== 2'b01) begin n_err++; $display("FAIL add_op: got %b want 01", op_sel); end
    wait_done(cyc);
    n_cmp++; if (done !== 1'b1 || cyc !== 10) begin n_err++;
      $display("FAIL add_done: done=%0b cycles=%0d want 1 10", done, cyc); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (in1[i/3][i%3] !== 8'sd100 || in2[i/3][i%3] !== 8'sd100) begin n_err++;
        $display("FAIL add_elem%0d: got %0d/%0d want 100/100", i, in1[i/3][i%3], in2[i/3][i%3]); end
    end
    tick();
    n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL add_start_count: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_reset_mid_load();
    int s0;
    int cyc;
    send_beat(8'h00);
    for (int i = 0; i < 5; i++) send_beat(8'd7);
    s0 = start_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ready !== 1'b1 || dbg_state !== 3'd0 || busy !== 1'b0) begin n_err++;
      $display("FAIL rml_idle: ready=%0b state=%0d busy=%0b want 1 0 0", ready, dbg_state, busy); end
    n_cmp++; if (op_sel !== 2'b00) begin n_err++; $display("FAIL rml_op: got %b want 00", op_sel); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (in1[r][c] !== 8'sd0 || in2[r][c] !== 8'sd0) begin n_err++;
          $display("FAIL rml_operand[%0d][%0d]: got %0d/%0d want 0/0", r, c, in1[r][c], in2[r][c]); end
      end
    tick(); tick();
    n_cmp++; if (start_cnt !== s0) begin n_err++; $display("FAIL rml_no_start: got %0d want %0d", start_cnt, s0); end
    // Fresh add with signed elements: A = i+1, B = -(i+1)
    send_beat(8'h01);
    for (int i = 0; i < 9; i++) send_beat(8'(i + 1));
    for (int i = 0; i < 9; i++) send_beat(8'(-(i + 1)));
    n_cmp++; if (start !== 1'b1 || op_sel !== 2'b01) begin n_err++;
      $display("FAIL rml_fresh_start: start=%0b op=%b want 1 01", start, op_sel); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (in1[i/3][i%3] !== 8'(i + 1) || in2[i/3][i%3] !== 8'(-(i + 1))) begin n_err++;
        $display("FAIL rml_fresh_elem%0d: got %0d/%0d want %0d/%0d", i, in1[i/3][i%3], in2[i/3][i%3], i + 1, -(i + 1)); end
    end
    wait_done(cyc);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rml_fresh_done: got %0b want 1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int k;
    int cyc;
    logic acc_done;
    send_beat(8'h00);
    for (int i = 0; i < 18; i++) send_beat(8'(2 * i));
    // In L+1: hold the next header valid through the WAIT window
    data  = 8'h02;
    valid = 1'b1;
    k = 0;
    while (!ready && k < 30) begin
      tick();
      k++;
    end
    acc_done = done;
    tick();
    valid = 1'b0;
    n_cmp++; if (k !== 10 || acc_done !== 1'b1) begin n_err++;
      $display("FAIL b2b_accept: cycles=%0d done=%0b want 10 1", k, acc_done); end
    n_cmp++; if (start !== 1'b1 || op_sel !== 2'b10) begin n_err++;
      $display("FAIL b2b_relu_start: start=%0b op=%b want 1 10", start, op_sel); end
    wait_done(cyc);
    n_cmp++; if (done !== 1'b1 || cyc !== 2) begin n_err++;
      $display("FAIL b2b_relu_done: done=%0b cycles=%0d want 1 2", done, cyc); end
    n_cmp++; if (in1[1][2] !== 8'sd10 || in2[2][2] !== 8'sd34) begin n_err++;
      $display("FAIL b2b_operands: a12=%0d b22=%0d want 10 34", in1[1][2], in2[2][2]); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_relu();
    test_illegal();
    test_add_gaps();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
